// File: rtl/mips_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// mips_seq_ctrl_if
// Memory handshake bundle between the sequencing controller and the
// instruction / data memories.
//   instr      : instruction word from instruction memory (valid with imem_ready)
//   imem_req   : instruction fetch request (controller -> imem)
//   imem_ready : instruction fetch complete (imem -> controller)
//   dmem_req   : data access request (controller -> dmem)
//   dmem_we    : data access direction, 1 = store (controller -> dmem)
//   dmem_ready : data access complete (dmem -> controller)
// -----------------------------------------------------------------------------
interface mips_seq_ctrl_if;
    logic [7:0] instr;
    logic       imem_req;
    logic       imem_ready;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ready;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  instr, imem_ready, dmem_ready
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output instr, imem_ready, dmem_ready
    );
endinterface

// File: rtl/mips_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mips_seq_ctrl
// Multi-cycle sequencing controller for an 8-bit MIPS-like core.
// Walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB) for each instruction and
// produces the datapath control strobes.
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   bus         : memory handshake bundle (master side)
//   zero        : ALU zero flag, used by beq in EXEC
//   ir          : latched current instruction
//   pc_en       : PC+1 pulse
//   pc_load     : load branch/jump target pulse
//   reg_we      : register-file write pulse
//   lireg       : li half select, 0 = upper half next, 1 = lower half next
//   alu_src, mem_to_reg, m, alu_ctrl : decoded datapath fields
//   instr_done  : retire pulse
//   state       : current FSM state
// -----------------------------------------------------------------------------
module mips_seq_ctrl (
    input  logic                   clk,
    input  logic                   rst,
    mips_seq_ctrl_if.master        bus,
    input  logic                   zero,
    output logic [7:0]             ir,
    output logic                   pc_en,
    output logic                   pc_load,
    output logic                   reg_we,
    output logic                   lireg,
    output logic                   alu_src,
    output logic                   mem_to_reg,
    output logic                   m,
    output logic [1:0]             alu_ctrl,
    output logic                   instr_done,
    output logic [2:0]             state
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [2:0] OP_LI   = 3'b000;
    localparam logic [2:0] OP_LW   = 3'b001;
    localparam logic [2:0] OP_SW   = 3'b010;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_J    = 3'b111;

    state_t     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic       lireg_q, lireg_d;
    logic       alu_src_q, alu_src_d;
    logic       mem_to_reg_q, mem_to_reg_d;
    logic       m_q, m_d;
    logic [1:0] alu_ctrl_q, alu_ctrl_d;

    logic       imem_req_c;
    logic       dmem_req_c;
    logic       dmem_we_c;
    logic       pc_en_c;
    logic       pc_load_c;
    logic       reg_we_c;
    logic       instr_done_c;
    logic [2:0] op;

    assign op = ir_q[7:5];

    // Returns {alu_src, mem_to_reg, m, alu_ctrl}. li alternates halves:
    // the first li of a pair (lireg=0) uses alu_ctrl=11, the second 00.
    function automatic logic [4:0] decode_fields(input logic [2:0] opc,
                                                 input logic      li_half);
        logic [4:0] f;
        case (opc)
            3'b000:  f = {3'b111, (li_half ? 2'b00 : 2'b11)};
            3'b001:  f = 5'b11000;
            3'b010:  f = 5'b10000;
            3'b011:  f = 5'b10000;
            3'b100:  f = 5'b00001;
            3'b101:  f = 5'b10010;
            default: f = 5'b00000;   // R-type and j
        endcase
        return f;
    endfunction

    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        lireg_d      = lireg_q;
        alu_src_d    = alu_src_q;
        mem_to_reg_d = mem_to_reg_q;
        m_d          = m_q;
        alu_ctrl_d   = alu_ctrl_q;
        imem_req_c   = 1'b0;
        dmem_req_c   = 1'b0;
        dmem_we_c    = 1'b0;
        pc_en_c      = 1'b0;
        pc_load_c    = 1'b0;
        reg_we_c     = 1'b0;
        instr_done_c = 1'b0;

        case (state_q)
            FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ready) begin
                    ir_d    = bus.instr;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                {alu_src_d, mem_to_reg_d, m_d, alu_ctrl_d} = decode_fields(op, lireg_q);
                state_d = EXEC;
            end
            EXEC: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEM;
                    OP_BEQ: begin
                        pc_load_c    = zero;
                        pc_en_c      = ~zero;
                        instr_done_c = 1'b1;
                        lireg_d      = 1'b0;
                        state_d      = FETCH;
                    end
                    OP_J: begin
                        pc_load_c    = 1'b1;
                        instr_done_c = 1'b1;
                        lireg_d      = 1'b0;
                        state_d      = FETCH;
                    end
                    default: state_d = WB;
                endcase
            end
            MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (op == OP_SW);
                if (bus.dmem_ready) begin
                    if (op == OP_SW) begin
                        pc_en_c      = 1'b1;
                        instr_done_c = 1'b1;
                        lireg_d      = 1'b0;
                        state_d      = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                reg_we_c     = 1'b1;
                pc_en_c      = 1'b1;
                instr_done_c = 1'b1;
                lireg_d      = (op == OP_LI) ? ~lireg_q : 1'b0;
                state_d      = FETCH;
            end
            default: state_d = FETCH;   // unused codes recover to FETCH
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            ir_q         <= 8'h00;
            lireg_q      <= 1'b0;
            alu_src_q    <= 1'b0;
            mem_to_reg_q <= 1'b0;
            m_q          <= 1'b0;
            alu_ctrl_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            lireg_q      <= lireg_d;
            alu_src_q    <= alu_src_d;
            mem_to_reg_q <= mem_to_reg_d;
            m_q          <= m_d;
            alu_ctrl_q   <= alu_ctrl_d;
        end
    end

    // Reset forces state to FETCH, so imem_req alone needs an explicit
    // gate to stay low while rst is held.
    assign bus.imem_req = imem_req_c & ~rst;
    assign bus.dmem_req = dmem_req_c;
    assign bus.dmem_we  = dmem_we_c;
    assign pc_en        = pc_en_c;
    assign pc_load      = pc_load_c;
    assign reg_we       = reg_we_c;
    assign instr_done   = instr_done_c;
    assign ir           = ir_q;
    assign lireg        = lireg_q;
    assign alu_src      = alu_src_q;
    assign mem_to_reg   = mem_to_reg_q;
    assign m            = m_q;
    assign alu_ctrl     = alu_ctrl_q;
    assign state        = state_q;

endmodule

// File: doc/mips_seq_ctrl.md
MIPS_SEQ_CTRL -- requirements
Module: mips_seq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-002 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-003 SHALL have port instr, input, 8: instruction word from instruction memory, valid when imem_ready=1.
REQ-004 SHALL have ports imem_req (output, 1: fetch request) and imem_ready (input, 1: fetch complete).
REQ-005 SHALL have ports dmem_req (output, 1), dmem_we (output, 1: 1=store) and dmem_ready (input, 1: access complete).
REQ-006 SHALL have port zero, input, 1: ALU zero flag, sampled in EXEC for beq.
REQ-007 SHALL have port ir, output, 8: latched current instruction.
REQ-008 SHALL have ports pc_en (output, 1: PC+1 pulse) and pc_load (output, 1: load branch/jump target pulse).
REQ-009 SHALL have ports reg_we (output, 1: register-file write pulse) and lireg (output, 1: 0=li upper half, 1=li lower half).
REQ-010 SHALL have ports alu_src, mem_to_reg, m (outputs, 1 each) and alu_ctrl (output, 2).
REQ-011 SHALL have ports instr_done (output, 1: retire pulse) and state (output, 3: current FSM state).

Function
REQ-012 SHALL implement FSM FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL go to FETCH on the next edge.
REQ-013 FETCH: imem_req=1; on imem_ready=1, ir<=instr and next=DECODE; else remain, imem_req held high.
REQ-014 DECODE: register alu_src, mem_to_reg, m, alu_ctrl from ir[7:5] and lireg; next=EXEC; fields hold until next DECODE.
REQ-015 Decode table (alu_src/mem_to_reg/m/alu_ctrl): 000 li: 1/1/1/(lireg=0?11:00); 001 lw: 1/1/0/00; 010 sw: 1/0/0/00; 011 addi: 1/0/0/00; 100 beq: 0/0/0/01; 101 slti: 1/0/0/10; 110 R-type: 0/0/0/00; 111 j: 0/0/0/00.
REQ-016 No output SHALL ever be driven z or x; don't-care fields SHALL be 0.
REQ-017 EXEC: lw/sw -> MEM; li, addi, slti, R-type -> WB; beq -> FETCH with pc_load=1 if zero=1 else pc_en=1; j -> FETCH with pc_load=1; beq and j assert instr_done in EXEC.
REQ-018 MEM: dmem_req=1, dmem_we=1 only for sw; wait for dmem_ready; lw -> WB; sw -> FETCH with pc_en=1 and instr_done=1 that cycle.
REQ-019 WB: reg_we=1, pc_en=1, instr_done=1 for exactly one cycle; next=FETCH.
REQ-020 pc_en, pc_load, reg_we, instr_done SHALL be one-cycle pulses, combinational from state, never simultaneously pc_en and pc_load.
REQ-021 lireg SHALL toggle on each li retire (WB with ir[7:5]=000) and clear to 0 on retire of any non-li instruction.
REQ-022 Minimum latency, FETCH entry to retire inclusive, imem/dmem ready immediately: beq/j 3 cycles; li/addi/slti/R-type/sw 4; lw 5.
REQ-023 imem_ready outside FETCH and dmem_ready outside MEM SHALL be ignored.
REQ-024 Request signals SHALL not drop before the matching ready; ready arriving same cycle as request SHALL complete that cycle.

Reset
REQ-025 On rst=1, immediately and independent of clk: state=FETCH, ir=0, lireg=0, alu_src=mem_to_reg=m=0, alu_ctrl=00, all pulses and requests 0 except imem_req, which SHALL be 0 while rst=1.
REQ-026 Reset asserted mid-operation (any state, including MEM with dmem_req=1) SHALL abort the instruction with no reg_we, pc_en or pc_load; first fetch SHALL begin on the first edge after rst falls.

Verification
REQ-027 addi 0x61, ready tied 1 -> states 0,1,2,4; reg_we, pc_en, instr_done pulse in cycle 4; alu_ctrl=00, alu_src=1.
REQ-028 li 0x05 then li 0x0A -> first alu_ctrl=11, lireg 0->1 at retire; second alu_ctrl=00, lireg ->0; add 0xC0 between li pair -> lireg cleared, second li again 11.
REQ-029 lw 0x22 with dmem_ready delayed 3 cycles -> dmem_req=1, dmem_we=0 for 4 cycles, then WB, reg_we=1, mem_to_reg=1; total 8 cycles.
REQ-030 beq 0x80 with zero=1 -> pc_load pulse in EXEC, no pc_en, no reg_we; with zero=0 -> pc_en pulse only; j 0xE3 -> pc_load, 3 cycles.
REQ-031 sw 0x41 -> dmem_we=1 in MEM, reg_we never asserted, pc_en with instr_done in MEM.
REQ-032 rst pulsed during MEM of lw -> state=0 and dmem_req=0 asynchronously, no reg_we, refetch after release; imem_ready pulsed in EXEC -> ignored.
